// File: rtl/fetch_control_pkg.sv
// cpuConfig: shared instruction-format widths, opcode/state enums and decode helpers
// for the fetch/control block.
package cpuConfig;
  localparam int OPCODE_W  = 3;
  localparam int FUNC_W    = 3;
  localparam int RD_W      = 3;
  localparam int OPERAND_W = 8;
  localparam int INSTR_W   = OPCODE_W + FUNC_W + RD_W + OPERAND_W;

  typedef logic [FUNC_W-1:0] aluFunc_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ALU   = 3'd1,
    OP_ALUI  = 3'd2,
    OP_ALUSW = 3'd3,
    OP_WAIT  = 3'd4,
    OP_JMP   = 3'd5,
    OP_BZ    = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    S_RUN          = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_WAIT_RELEASE = 2'd2,
    S_HALT         = 2'd3
  } state_t;

  function automatic logic is_reg_write(opcode_t op);
    return (op == OP_ALU) || (op == OP_ALUI) || (op == OP_ALUSW);
  endfunction

  function automatic logic is_imm_op(opcode_t op);
    return (op == OP_ALUI) || (op == OP_ALUSW);
  endfunction
endpackage

// File: rtl/fetch_control_rom.sv
// prog_rom: combinational program ROM; contents arrive as a flattened image
// (word a at bits [a*WORD_W +: WORD_W]) generated from the program hex file.
module prog_rom #(
  parameter int P_SIZE = 6,
  parameter int WORD_W = 17,
  parameter logic [(2**P_SIZE)*WORD_W-1:0] ROM_IMAGE = '0
) (
  input  logic [P_SIZE-1:0] i_addr,
  output logic [WORD_W-1:0] o_data
);
  logic [WORD_W-1:0] w_mem [2**P_SIZE];

  for (genvar g = 0; g < 2**P_SIZE; g++) begin : g_word
    assign w_mem[g] = ROM_IMAGE[g*WORD_W +: WORD_W];
  end

  assign o_data = w_mem[i_addr];
endmodule

// File: rtl/fetch_control.sv
// fetch_control: single-issue fetch/decode sequencer with WAIT-button handshake and HALT.
// Define FETCH_CONTROL_BTN_SYNC_EN to pass the WAIT button through a 2-flop synchronizer.
module fetch_control
  import cpuConfig::*;
#(
  parameter int N      = 8,
  parameter int A_SIZE = 3,
  parameter int R_SIZE = 3,
  parameter int P_SIZE = 6,
  parameter logic [(2**P_SIZE)*(OPCODE_W+A_SIZE+R_SIZE+N)-1:0] ROM_IMAGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        switchesIn,
  input  logic              zeroIn,
  output logic              writeReg,
  output aluFunc_t          aluFunc,
  output logic              aluImmediate,
  output logic              immSwitches,
  output logic [R_SIZE-1:0] opD,
  output logic [N-1:0]      opS,
  output logic [P_SIZE-1:0] pcOut,
  output logic              halted
);
  localparam int WORD_W = OPCODE_W + A_SIZE + R_SIZE + N;

  logic [WORD_W-1:0] w_instr;
  opcode_t           w_op;
  state_t            r_state;
  logic [P_SIZE-1:0] r_pc;
  logic [P_SIZE-1:0] w_pc_inc;
  logic [P_SIZE-1:0] w_target;
  logic              w_btn;
  logic              w_unused;

  prog_rom #(
    .P_SIZE   (P_SIZE),
    .WORD_W   (WORD_W),
    .ROM_IMAGE(ROM_IMAGE)
  ) u_rom (
    .i_addr(r_pc),
    .o_data(w_instr)
  );

  assign w_op     = opcode_t'(w_instr[WORD_W-1 -: OPCODE_W]);
  assign w_pc_inc = r_pc + P_SIZE'(1'b1);
  assign w_target = w_instr[P_SIZE-1:0];
  // Low switch bits belong to the datapath's immediate path, not to sequencing.
  assign w_unused = ^switchesIn[8:0];

`ifdef FETCH_CONTROL_BTN_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], switchesIn[9]};
    end
  end

  assign w_btn = r_sync[1];
`else
  assign w_btn = switchesIn[9];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          case (w_op)
            OP_WAIT: r_state <= S_WAIT_PRESS;
            OP_HALT: r_state <= S_HALT;
            OP_JMP:  r_pc    <= w_target;
            OP_BZ:   r_pc    <= zeroIn ? w_target : w_pc_inc;
            default: r_pc    <= w_pc_inc;
          endcase
        end
        S_WAIT_PRESS: begin
          if (w_btn) r_state <= S_WAIT_RELEASE;
        end
        // Advance only on release so one press yields exactly one step.
        S_WAIT_RELEASE: begin
          if (!w_btn) begin
            r_state <= S_RUN;
            r_pc    <= w_pc_inc;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    writeReg     = 1'b0;
    aluImmediate = 1'b0;
    immSwitches  = 1'b0;
    if (r_state == S_RUN) begin
      writeReg     = !reset && is_reg_write(w_op);
      aluImmediate = is_imm_op(w_op);
      immSwitches  = (w_op == OP_ALUSW);
    end else begin
      writeReg     = 1'b0;
      aluImmediate = 1'b0;
      immSwitches  = 1'b0;
    end
  end

  assign aluFunc = aluFunc_t'(w_instr[N+R_SIZE +: A_SIZE]);
  assign opD     = w_instr[N +: R_SIZE];
  assign opS     = w_instr[N-1:0];
  assign pcOut   = r_pc;
  assign halted  = (r_state == S_HALT);
endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed table, hand-written corner sequences,
// and randomized inputs checked against a cycle-level reference model.
module tb_fetch_control;
  localparam int NB    = 8;
  localparam int PB    = 6;
  localparam int DEPTH = 64;
  localparam int WW    = 17;
`ifdef FETCH_CONTROL_BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int M_RUN = 0, M_PRESS = 1, M_RELEASE = 2, M_HALT = 3;

  function automatic logic [WW-1:0] mk(int op, int f, int rd, int opnd);
    return {3'(op), 3'(f), 3'(rd), 8'(opnd)};
  endfunction

  // Test program (opcodes: 0 NOP 1 ALU 2 ALUI 3 ALUSW 4 WAIT 5 JMP 6 BZ 7 HALT).
  function automatic logic [WW-1:0] prog_word(int a);
    case (a)
      0:       return mk(2, 3, 2, 'h05);
      1:       return mk(4, 0, 0, 'h00);
      2:       return mk(1, 1, 3, 'h04);
      3:       return mk(3, 2, 1, 'h00);
      4:       return mk(6, 0, 0, 'h10);
      6:       return mk(5, 0, 0, 'h3E);
      16:      return mk(2, 5, 4, 'hA5);
      17:      return mk(5, 0, 0, 'h3E);
      32:      return mk(4, 6, 5, 'h00);
      33:      return mk(7, 0, 0, 'h00);
      62:      return mk(1, 7, 7, 'hFF);
      63:      return mk(6, 0, 0, 'h20);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DEPTH*WW-1:0] build_image();
    logic [DEPTH*WW-1:0] img;
    img = '0;
    for (int a = 0; a < DEPTH; a++) img[a*WW +: WW] = prog_word(a);
    return img;
  endfunction

  localparam logic [DEPTH*WW-1:0] IMAGE = build_image();

  logic                 clk;
  logic                 reset;
  logic [9:0]           switchesIn;
  logic                 zeroIn;
  logic                 writeReg;
  cpuConfig::aluFunc_t  aluFunc;
  logic                 aluImmediate;
  logic                 immSwitches;
  logic [2:0]           opD;
  logic [NB-1:0]        opS;
  logic [PB-1:0]        pcOut;
  logic                 halted;

  fetch_control #(.N(NB), .A_SIZE(3), .R_SIZE(3), .P_SIZE(PB), .ROM_IMAGE(IMAGE)) dut (
    .clk(clk), .reset(reset), .switchesIn(switchesIn), .zeroIn(zeroIn),
    .writeReg(writeReg), .aluFunc(aluFunc), .aluImmediate(aluImmediate),
    .immSwitches(immSwitches), .opD(opD), .opS(opS), .pcOut(pcOut), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: program counter, mode, and the button as the FSM sees it.
  int m_pc   = 0;
  int m_mode = M_RUN;
  bit m_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, model pc=%0d)", name, act, exp, $time, m_pc);
    end
  endtask

  function automatic void model_clear_hist();
    m_hist.delete();
    for (int i = 0; i < SYNC_LAT; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step(logic rst, logic btn, logic z);
    logic [WW-1:0] wd;
    int  op, tgt, nxt;
    bit  seen;
    wd  = prog_word(m_pc);
    op  = int'(wd[16:14]);
    tgt = int'(wd[7:0]) % DEPTH;
    nxt = (m_pc + 1) % DEPTH;
    m_hist.push_back(btn);
    seen = m_hist.pop_front();
    if (rst) begin
      m_pc   = 0;
      m_mode = M_RUN;
      model_clear_hist();
    end else begin
      case (m_mode)
        M_RUN: begin
          if (op == 4)                         m_mode = M_PRESS;
          else if (op == 7)                    m_mode = M_HALT;
          else if (op == 5 || (op == 6 && z))  m_pc   = tgt;
          else                                 m_pc   = nxt;
        end
        M_PRESS:   if (seen) m_mode = M_RELEASE;
        M_RELEASE: if (!seen) begin m_mode = M_RUN; m_pc = nxt; end
        default: ;
      endcase
    end
  endfunction

  task automatic check_model();
    logic [WW-1:0] wd;
    int  op;
    bit  run;
    wd  = prog_word(m_pc);
    op  = int'(wd[16:14]);
    run = (m_mode == M_RUN);
    chk("pcOut", pcOut, m_pc);
    chk("halted", halted, m_mode == M_HALT);
    chk("writeReg", writeReg, run && !reset && op >= 1 && op <= 3);
    chk("aluImmediate", aluImmediate, run && (op == 2 || op == 3));
    chk("immSwitches", immSwitches, run && op == 3);
    chk("aluFunc", aluFunc, wd[13:11]);
    chk("opD", opD, wd[10:8]);
    chk("opS", opS, wd[7:0]);
  endtask

  task automatic drive(input logic rst, input logic btn, input logic z);
    reset      = rst;
    switchesIn = {btn, 9'($urandom)};
    zeroIn     = z;
  endtask

  // One cycle: drive at negedge, compare against model, then step model at the edge.
  task automatic tick(input logic rst, input logic btn, input logic z);
    @(negedge clk);
    drive(rst, btn, z);
    #1;
    check_model();
    @(posedge clk);
    model_step(rst, btn, z);
    #1;
  endtask

  typedef struct {
    logic rst; logic btn; logic z;
    int pc; logic wr; logic imm; int ops; logic h;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic rst, logic btn, int pc, logic wr, logic imm, int ops);
    vec_t v;
    v = '{rst, btn, 1'b0, pc, wr, imm, ops, 1'b0};
    tbl.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rb;
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0);
    #1;

    // Outputs expected during each cycle (before the edge that consumes the row).
    add(1'b1, 1'b0, 0, 1'b0, 1'b1, 'h05);                 // reset forces writeReg low
    add(1'b0, 1'b0, 0, 1'b1, 1'b1, 'h05);                 // ALUI rd=2 imm=5
    add(1'b0, 1'b0, 1, 1'b0, 1'b0, 'h00);                 // WAIT issues
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 1, 1'b0, 1'b0, 'h00);
    for (int i = 0; i < 4; i++)  add(1'b0, 1'b1, 1, 1'b0, 1'b0, 'h00);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].btn, tbl[i].z);
      #1;
      chk("tbl_pc", pcOut, tbl[i].pc);
      chk("tbl_wr", writeReg, tbl[i].wr);
      chk("tbl_imm", aluImmediate, tbl[i].imm);
      chk("tbl_opS", opS, tbl[i].ops);
      chk("tbl_halt", halted, tbl[i].h);
      check_model();
      @(posedge clk);
      model_step(tbl[i].rst, tbl[i].btn, tbl[i].z);
      #1;
    end

    // Release: exactly one advance, after the synchronizer latency.
    for (int i = 0; i < SYNC_LAT; i++) begin tick(1'b0, 1'b0, 1'b0); chk("rel_hold", pcOut, 1); end
    tick(1'b0, 1'b0, 1'b0); chk("rel_adv", pcOut, 2);
    tick(1'b0, 1'b0, 1'b0); chk("one_adv", pcOut, 3);
    chk("alusw_sw", immSwitches, 1'b1);
    tick(1'b0, 1'b0, 1'b0); chk("to_bz", pcOut, 4);
    tick(1'b0, 1'b0, 1'b1); chk("bz_taken", pcOut, 'h10);
    chk("alui_opS", opS, 'hA5);
    tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); chk("jmp", pcOut, 62);
    tick(1'b0, 1'b0, 1'b0); chk("pc63", pcOut, 63);
    tick(1'b0, 1'b0, 1'b0); chk("wrap", pcOut, 0);

    // Button already held when WAIT issues: leave WAIT_PRESS at once, then need release.
    tick(1'b0, 1'b1, 1'b0); chk("held_pc", pcOut, 1);
    for (int i = 0; i < 4; i++) begin tick(1'b0, 1'b1, 1'b0); chk("held_wait", pcOut, 1); end
    for (int i = 0; i < SYNC_LAT; i++) begin tick(1'b0, 1'b0, 1'b0); chk("held_rel", pcOut, 1); end
    tick(1'b0, 1'b0, 1'b0); chk("held_adv", pcOut, 2);

    tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0); chk("bz_not_taken", pcOut, 5);
    tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1); chk("bz63_taken", pcOut, 'h20);

    // Reset while in WAIT_RELEASE with the button still held.
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 + SYNC_LAT; i++) begin tick(1'b0, 1'b1, 1'b0); chk("wr_hold", pcOut, 'h20); end
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_pc", pcOut, 0); chk("rst_halt", halted, 1'b0); chk("rst_wr", writeReg, 1'b0);
    tick(1'b0, 1'b1, 1'b0); chk("rst_no_spurious", pcOut, 1);

    // Run to HALT, then check it holds for 20 cycles.
    for (int i = 0; i < 400 && m_mode != M_HALT; i++) tick(1'b0, (i % 6) < 3, m_pc == 63);
    chk("halt_reached", halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'($urandom), 1'($urandom));
      chk("halt_pc", pcOut, 33); chk("halt_wr", writeReg, 1'b0); chk("halt_flag", halted, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0); chk("halt_rst_pc", pcOut, 0); chk("halt_rst_flag", halted, 1'b0);

    // Randomized phase against the model.
    rb = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) rb = ~rb;
      tick($urandom_range(63) == 0, rb, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
